bsmul_ctrl: RTL and testbench

BSMUL_CTRL -- requirements
Module: bsmul_ctrl

---
 rtl/bsmul_pkg.sv | 17 +
 rtl/bsmul_cell.sv | 37 +++
 rtl/bsmul_ctrl.sv | 124 ++++++++++++
 tb/tb_bsmul_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bsmul_pkg.sv
// Shared types and constants for the bit-serial multiplier controller.
package bsmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsmul_state_e;

  localparam int BSMUL_W = 8;

  // Accepting edge to out_valid rising edge, in clock edges.
  function automatic int bsmul_lat(input int w);
    return 2 * w + 3;
  endfunction

endpackage

// File: rtl/bsmul_cell.sv
// One bit of the serial-parallel multiplier row: adds the partial product
// of the broadcast serial bit and its held b bit into the incoming sum.
module bsmul_cell (
  input  logic clk,
  input  logic reset,
  input  logic x_i,
  input  logic b_i,
  input  logic sync_i,
  input  logic sum_i,
  output logic sum_o
);

  logic       sum_q, sum_d;
  logic       carry_q, carry_d;
  logic [1:0] total;

  // sync marks the first serial bit: nothing valid is upstream yet, so both
  // the stale carry and the stale sum from the previous product are dropped.
  always_comb begin
    total   = {1'b0, sum_i & ~sync_i} + {1'b0, x_i & b_i} + {1'b0, carry_q & ~sync_i};
    sum_d   = total[0];
    carry_d = total[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/bsmul_ctrl.sv
// Bit-serial multiplier with valid/ready handshake, fixed latency 2W+3.
// Define BSMUL_SIGNED_EN for two's-complement operands (default: unsigned).
module bsmul_ctrl
  import bsmul_pkg::*;
#(
  parameter int W = BSMUL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p,
  output logic             busy
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(PW + 2);
  localparam logic [CW-1:0] CNT_SHIFT_END = CW'(PW);
  localparam logic [CW-1:0] CNT_LAST      = CW'(PW + 1);

  function automatic logic [PW-1:0] extend(input logic [W-1:0] v);
`ifdef BSMUL_SIGNED_EN
    return {{W{v[W-1]}}, v};
`else
    return {{W{1'b0}}, v};
`endif
  endfunction

  bsmul_state_e    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   a_q, a_d;
  logic [PW-1:0]   b_q, b_d;
  logic [PW-1:0]   res_q, res_d;
  logic            ov_q, ov_d;
  logic            accept, run, sync, ser_bit, shift_en;
  logic [PW:0]     chain;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (ov_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    busy      = (state_q == RUN);
    out_valid = ov_q;
    p         = ov_q ? res_q : '0;
  end

  // Datapath next-state
  always_comb begin
    accept   = in_ready && in_valid;
    run      = (state_q == RUN);
    sync     = run && (cnt_q == '0);
    ser_bit  = run && a_q[0];
    // Product bit k leaves the row one cycle after serial bit k enters it.
    shift_en = run && (cnt_q != '0) && (cnt_q <= CNT_SHIFT_END);

    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    if (accept) begin
      cnt_d = '0;
      a_d   = extend(a);
      b_d   = extend(b);
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
      a_d   = a_q >> 1;
    end

    res_d = shift_en ? {chain[PW], res_q[PW-1:1]} : res_q;
    // out_valid trails DONE entry by one edge and drops on the handshake.
    ov_d  = (state_q == DONE) && !(ov_q && out_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      res_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      res_q <= res_d;
      ov_q  <= ov_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  // Cell 0 holds the b MSB; sums ripple toward the b LSB cell, whose output
  // is the serial product stream.
  assign chain[0] = 1'b0;

  for (genvar j = 0; j < PW; j++) begin : g_cell
    bsmul_cell u_cell (
      .clk    (clk),
      .reset  (reset),
      .x_i    (ser_bit),
      .b_i    (b_q[PW-1-j]),
      .sync_i (sync),
      .sum_i  (chain[j]),
      .sum_o  (chain[j+1])
    );
  end

endmodule

// File: tb/tb_bsmul_ctrl.sv
// Directed-vector and random bench for bsmul_ctrl at W=8, either operand mode.
module tb_bsmul_ctrl;
  import bsmul_pkg::*;

  localparam int W  = BSMUL_W;
  localparam int NV = 8;

  logic           clk = 1'b0;
  logic           reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] p;
  int             checks = 0;
  int             failures = 0;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  bsmul_ctrl #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe, ye;
`ifdef BSMUL_SIGNED_EN
    xe = {{W{x[W-1]}}, x};
    ye = {{W{y[W-1]}}, y};
`else
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
`endif
    return xe * ye;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
  endtask

  // Full transaction: accept, count latency, check result, then handshake.
  task automatic do_txn(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] ep, input string tag);
    int   n;
    logic rdy_bad, p_bad;
    wait_ready(tag);
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick;
    a = W'($urandom);
    b = W'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    rdy_bad = 1'b0;
    p_bad = 1'b0;
    while (out_valid !== 1'b1 && n < 100) begin
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      if (p !== '0) p_bad = 1'b1;
      tick;
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(bsmul_lat(W)));
    check({tag, "_p"}, 32'(p), 32'(ep));
    check({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);
    check({tag, "_p_zero"}, 32'(p_bad), 32'd0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_next"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int   n;
    logic bad;
    logic [W-1:0] ra, rb;

`ifdef BSMUL_SIGNED_EN
    vecs[0] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[1] = '{8'h80, 8'h7F, 16'hC080};
    vecs[2] = '{8'd3,  8'd5,  16'd15};
    vecs[3] = '{8'hFD, 8'd5,  16'hFFF1};
    vecs[4] = '{8'h80, 8'h80, 16'h4000};
    vecs[5] = '{8'd0,  8'hA5, 16'h0000};
    vecs[6] = '{8'd7,  8'd9,  16'd63};
    vecs[7] = '{8'h7F, 8'h7F, 16'h3F01};
`else
    vecs[0] = '{8'd3,  8'd5,  16'd15};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'd0,  8'hA5, 16'h0000};
    vecs[3] = '{8'd7,  8'd9,  16'd63};
    vecs[4] = '{8'h80, 8'h02, 16'h0100};
    vecs[5] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[6] = '{8'hAA, 8'h55, 16'h3872};
    vecs[7] = '{8'h12, 8'h34, 16'h03A8};
`endif

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    tick;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick;
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready_after", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++)
      do_txn(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // Backpressure in DONE with ignored in_valid pulses, then back-to-back.
    wait_ready("bp");
    a = 8'h12;
    b = 8'h34;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    check("bp_lat", 32'(n), 32'(bsmul_lat(W)));
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = W'($urandom);
      b = W'($urandom);
      tick;
      if (out_valid !== 1'b1 || p !== 16'h03A8 || in_ready !== 1'b0) bad = 1'b1;
    end
    in_valid = 1'b0;
    check("bp_stable", 32'(bad), 32'd0);
    check("bp_p", 32'(p), 32'h03A8);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("bp_ready_next", 32'(in_ready), 32'd1);
    do_txn(8'd3, 8'd5, 16'd15, "b2b");

    // Reset at RUN cycle k=5 aborts the operation.
    wait_ready("abort");
    a = 8'h55;
    b = 8'h33;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_in_ready_rst", 32'(in_ready), 32'd0);
    tick;
    reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_p", 32'(p), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    bad = 1'b0;
    repeat (25) begin
      tick;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    check("abort_no_valid", 32'(bad), 32'd0);
    do_txn(8'd7, 8'd9, 16'd63, "fresh");

    for (int i = 0; i < 1500; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_txn(ra, rb, ref_mul(ra, rb), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
